mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of requesting caches; legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 64: request address width.
REQ-003 SHALL have parameter DATA_W, default 128: cache-line data width.
REQ-004 SHALL have parameter TAG_W, default 2: memory tag width.
REQ-005 SHALL have parameter MAX_OUT, default 1: maximum outstanding memory transactions; legal range 1..8.
REQ-006 SHALL have parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-007 SHALL use one clock and an asynchronous, active-low reset.
REQ-008 Port clk  in  1  clock; all state SHALL update on its rising edge.
REQ-009 Port reset_n  in  1  asynchronous active-low reset.
REQ-010 Port req_valid  in  N_PORTS  per-port request strobe.
REQ-011 Port req_addr  in  N_PORTS*ADDR_W  per-port address; port i occupies slice i.
REQ-012 Port req_store_data  in  N_PORTS*DATA_W  per-port store line.
REQ-013 Port req_tag  in  N_PORTS*TAG_W  per-port tag.
REQ-014 Port req_opcode  in  N_PORTS*4  per-port opcode.
REQ-015 Port req_ack  out  N_PORTS  one-cycle pulse when a port's request issues to memory.
REQ-016 Port rsp_valid  out  N_PORTS  one-cycle, one-hot response strobe.
REQ-017 Port rsp_load_data  out  DATA_W  response line, broadcast to all ports.
REQ-018 Ports mem_req_valid (out, 1), mem_req_ready (in, 1), mem_req_addr (out, ADDR_W), mem_req_store_data (out, DATA_W), mem_req_tag (out, TAG_W), mem_req_opcode (out, 4): memory request channel.
REQ-019 Ports mem_rsp_valid (in, 1), mem_rsp_load_data (in, DATA_W): in-order memory response channel.
REQ-020 Status ports: outstanding (out, 4) = current in-flight count; rsp_err (out, 1) = sticky unexpected-response flag.

Function
REQ-021 Per-port holding slot: req_valid[i] high with pend[i]=0 -> payload captured and pend[i]=1 at that edge; req_valid[i] while pend[i]=1 ignored, slot unchanged.
REQ-022 Candidates = ports with pend=1. PRIO_MODE=0: first candidate at or after rr_ptr, modulo N_PORTS. PRIO_MODE=1: lowest candidate index.
REQ-023 Load condition: candidate exists AND (mem_req_valid=0 OR mem_req_ready=1) AND (outstanding < MAX_OUT OR a response pops this cycle).
REQ-024 On load: output register takes winner's payload; mem_req_valid=1 next cycle; pend[winner] cleared; winner ID pushed to order FIFO (depth MAX_OUT); req_ack[winner] pulses next cycle; rr_ptr = (winner+1) mod N_PORTS.
REQ-025 Minimum latency: req_valid sampled at edge k -> mem_req_valid and req_ack high after edge k+1.
REQ-026 mem_req_valid and the mem_req_* payload SHALL hold stable until mem_req_ready=1; mem_req_valid then drops unless a new load occurs the same edge.
REQ-027 outstanding: +1 on load, -1 on response pop, unchanged if both occur the same edge; never exceeds MAX_OUT.
REQ-028 mem_rsp_valid with FIFO non-empty: pop head, rsp_valid[head]=1 and rsp_load_data=mem_rsp_load_data, combinationally, same cycle.
REQ-029 mem_rsp_valid with FIFO empty: no rsp_valid, rsp_err set to 1 and held until reset.
REQ-030 A port's capture and the clearing of its pend bit on the same edge SHALL resolve with clear winning; a new capture is accepted the following cycle.
REQ-031 FIFO pointers SHALL wrap modulo MAX_OUT; with N_PORTS=2, MAX_OUT=1, PRIO_MODE=0, behaviour matches the existing two-cache L1D/L1I arbitration.

Reset
REQ-032 reset_n low SHALL asynchronously clear pend, the FIFO, outstanding, rr_ptr (to 0), rsp_err, mem_req_valid, req_ack and rsp_valid; reset mid-transaction discards all in-flight state, and responses arriving after release set rsp_err.
REQ-033 Outputs SHALL be 0 throughout reset and until the first load after release.

Verification
REQ-034 Single request: port1 pulses addr 0x1000, mem_req_ready=1 -> mem_req_valid and req_ack[1] after 2 edges with addr 0x1000; mem_rsp 3 cycles later -> rsp_valid=0b10.
REQ-035 Round-robin contention, N_PORTS=4: all ports pending, always ready -> grant order 0,1,2,3,0; PRIO_MODE=1 -> 0 is granted every time it is re-requested.
REQ-036 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid and payload stable for 5 cycles; req_ack fires once.
REQ-037 MAX_OUT=2: three ports request, no responses -> exactly 2 issues, outstanding=2; a response to port A plus a same-edge load -> outstanding stays 2, and rsp_valid follows issue order.
REQ-038 Spurious response with outstanding=0 -> no rsp_valid, rsp_err=1 until reset_n low.
REQ-039 Assert reset_n low mid-flight with outstanding=1 -> all outputs 0 immediately; after release, a new request issues normally.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Memory request arbiter: per-port holding slots, round-robin or fixed
// priority selection, registered request channel, in-order response routing.
module mem_req_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 128,
    parameter int TAG_W     = 2,
    parameter int MAX_OUT   = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_PORTS-1:0]        req_valid,
    input  logic [N_PORTS*ADDR_W-1:0] req_addr,
    input  logic [N_PORTS*DATA_W-1:0] req_store_data,
    input  logic [N_PORTS*TAG_W-1:0]  req_tag,
    input  logic [N_PORTS*4-1:0]      req_opcode,
    output logic [N_PORTS-1:0]        req_ack,
    output logic [N_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_load_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [DATA_W-1:0]         mem_req_store_data,
    output logic [TAG_W-1:0]          mem_req_tag,
    output logic [3:0]                mem_req_opcode,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_W-1:0]         mem_rsp_load_data,
    output logic [3:0]                outstanding,
    output logic                      rsp_err
);

    localparam int IDW = $clog2(N_PORTS);
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SW  = IDW + 1;

    logic [N_PORTS-1:0]             pend_q, pend_d;
    logic [N_PORTS-1:0]             cap;
    logic [N_PORTS-1:0][ADDR_W-1:0] slot_addr_q;
    logic [N_PORTS-1:0][DATA_W-1:0] slot_data_q;
    logic [N_PORTS-1:0][TAG_W-1:0]  slot_tag_q;
    logic [N_PORTS-1:0][3:0]        slot_op_q;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           has_cand;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cidx;
    logic [SW-1:0]  csum;
    logic [SW-1:0]  rsum;

    logic              mv_q, mv_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [TAG_W-1:0]  mtag_q, mtag_d;
    logic [3:0]        mop_q, mop_d;
    logic [N_PORTS-1:0] ack_q, ack_d;

    logic [IDW-1:0] fifo_q [2**PW];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [IDW-1:0] head_id;
    logic [3:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           pop;
    logic           load;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUT - 1)) return '0;
        return p + PW'(1);
    endfunction

    // A slot only captures while empty, so a same-edge clear always wins.
    always_comb begin
        cap = req_valid & ~pend_q;
    end

    // Holding slot payload storage; validity is tracked by pend_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (cap[i]) begin
                slot_addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
                slot_data_q[i] <= req_store_data[i*DATA_W +: DATA_W];
                slot_tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
                slot_op_q[i]   <= req_opcode[i*4 +: 4];
            end
        end
    end

    // Winner search: scan from rr_ptr (round-robin) or from port 0.
    always_comb begin
        has_cand = 1'b0;
        win      = '0;
        cidx     = '0;
        csum     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            csum = {1'b0, rr_ptr_q} + SW'(k);
            if (csum >= SW'(N_PORTS)) csum = csum - SW'(N_PORTS);
            cidx = (PRIO_MODE == 1) ? IDW'(k) : csum[IDW-1:0];
            if (!has_cand && pend_q[cidx]) begin
                has_cand = 1'b1;
                win      = cidx;
            end
        end
    end

    // Issue and response-pop qualifiers.
    always_comb begin
        head_id = fifo_q[head_q];
        pop     = mem_rsp_valid && (cnt_q != 4'd0);
        load    = has_cand && (!mv_q || mem_req_ready) &&
                  ((cnt_q < 4'(MAX_OUT)) || pop);
    end

    // Responses route combinationally to the port at the FIFO head.
    always_comb begin
        rsp_valid     = '0;
        rsp_load_data = '0;
        if (pop) begin
            rsp_valid[head_id] = 1'b1;
            rsp_load_data      = mem_rsp_load_data;
        end
    end

    // Next-state for slots, output register, order FIFO and counters.
    always_comb begin
        pend_d   = pend_q | cap;
        ack_d    = '0;
        rr_ptr_d = rr_ptr_q;
        mv_d     = mv_q && !mem_req_ready;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        mtag_d   = mtag_q;
        mop_d    = mop_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        rsum     = {1'b0, win} + SW'(1);
        if (rsum >= SW'(N_PORTS)) rsum = rsum - SW'(N_PORTS);
        if (load) begin
            pend_d[win] = 1'b0;
            ack_d[win]  = 1'b1;
            rr_ptr_d    = rsum[IDW-1:0];
            mv_d        = 1'b1;
            maddr_d     = slot_addr_q[win];
            mdata_d     = slot_data_q[win];
            mtag_d      = slot_tag_q[win];
            mop_d       = slot_op_q[win];
            tail_d      = ptr_inc(tail_q);
        end
        if (pop) head_d = ptr_inc(head_q);
        case ({load, pop})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (mem_rsp_valid && (cnt_q == 4'd0));
    end

    // Issue-order FIFO storage; occupancy equals the outstanding count.
    always_ff @(posedge clk) begin
        if (load) fifo_q[tail_q] <= win;
    end

    // Control and output state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            rr_ptr_q <= '0;
            mv_q     <= 1'b0;
            maddr_q  <= '0;
            mdata_q  <= '0;
            mtag_q   <= '0;
            mop_q    <= '0;
            ack_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            mv_q     <= mv_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            mtag_q   <= mtag_d;
            mop_q    <= mop_d;
            ack_q    <= ack_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign req_ack            = ack_q;
    assign mem_req_valid      = mv_q;
    assign mem_req_addr       = maddr_q;
    assign mem_req_store_data = mdata_q;
    assign mem_req_tag        = mtag_q;
    assign mem_req_opcode     = mop_q;
    assign outstanding        = cnt_q;
    assign rsp_err            = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: default, 4-port round-robin and
// 4-port fixed-priority/two-outstanding configurations.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic reset_n;

    logic [1:0]   a_rv, a_ack, a_rspv;
    logic [127:0] a_addr, a_rld, a_mdata, a_mrspd;
    logic [255:0] a_data;
    logic [3:0]   a_tag, a_mop, a_out;
    logic [7:0]   a_op;
    logic         a_mv, a_rdy, a_mrspv, a_err;
    logic [63:0]  a_maddr;
    logic [1:0]   a_mtag;

    logic [3:0]   b_rv, b_ack, b_rspv, b_mop, b_out;
    logic [255:0] b_addr;
    logic [511:0] b_data;
    logic [7:0]   b_tag;
    logic [15:0]  b_op;
    logic [127:0] b_rld, b_mdata, b_mrspd;
    logic         b_mv, b_rdy, b_mrspv, b_err;
    logic [63:0]  b_maddr;
    logic [1:0]   b_mtag;

    logic [3:0]   c_rv, c_ack, c_rspv, c_mop, c_out;
    logic [255:0] c_addr;
    logic [511:0] c_data;
    logic [7:0]   c_tag;
    logic [15:0]  c_op;
    logic [127:0] c_rld, c_mdata, c_mrspd;
    logic         c_mv, c_rdy, c_mrspv, c_err;
    logic [63:0]  c_maddr;
    logic [1:0]   c_mtag;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mem_req_arbiter u_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_rv), .req_addr(a_addr),
        .req_store_data(a_data), .req_tag(a_tag),
        .req_opcode(a_op), .req_ack(a_ack),
        .rsp_valid(a_rspv), .rsp_load_data(a_rld),
        .mem_req_valid(a_mv), .mem_req_ready(a_rdy),
        .mem_req_addr(a_maddr), .mem_req_store_data(a_mdata),
        .mem_req_tag(a_mtag), .mem_req_opcode(a_mop),
        .mem_rsp_valid(a_mrspv), .mem_rsp_load_data(a_mrspd),
        .outstanding(a_out), .rsp_err(a_err)
    );

    mem_req_arbiter #(.N_PORTS(4), .MAX_OUT(8), .PRIO_MODE(0)) u_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_rv), .req_addr(b_addr),
        .req_store_data(b_data), .req_tag(b_tag),
        .req_opcode(b_op), .req_ack(b_ack),
        .rsp_valid(b_rspv), .rsp_load_data(b_rld),
        .mem_req_valid(b_mv), .mem_req_ready(b_rdy),
        .mem_req_addr(b_maddr), .mem_req_store_data(b_mdata),
        .mem_req_tag(b_mtag), .mem_req_opcode(b_mop),
        .mem_rsp_valid(b_mrspv), .mem_rsp_load_data(b_mrspd),
        .outstanding(b_out), .rsp_err(b_err)
    );

    mem_req_arbiter #(.N_PORTS(4), .MAX_OUT(2), .PRIO_MODE(1)) u_c (
        .clk(clk), .reset_n(reset_n),
        .req_valid(c_rv), .req_addr(c_addr),
        .req_store_data(c_data), .req_tag(c_tag),
        .req_opcode(c_op), .req_ack(c_ack),
        .rsp_valid(c_rspv), .rsp_load_data(c_rld),
        .mem_req_valid(c_mv), .mem_req_ready(c_rdy),
        .mem_req_addr(c_maddr), .mem_req_store_data(c_mdata),
        .mem_req_tag(c_mtag), .mem_req_opcode(c_mop),
        .mem_rsp_valid(c_mrspv), .mem_rsp_load_data(c_mrspd),
        .outstanding(c_out), .rsp_err(c_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        a_rv = '0; a_addr = '0; a_data = '0; a_tag = '0; a_op = '0;
        a_rdy = 1'b0; a_mrspv = 1'b0; a_mrspd = '0;
        b_rv = '0; b_addr = '0; b_data = '0; b_tag = '0; b_op = '0;
        b_rdy = 1'b1; b_mrspv = 1'b0; b_mrspd = '0;
        c_rv = '0; c_addr = '0; c_data = '0; c_tag = '0; c_op = '0;
        c_rdy = 1'b1; c_mrspv = 1'b0; c_mrspd = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_a_mv", 128'(a_mv), 128'(0));
        chk("rst_a_ack", 128'(a_ack), 128'(0));
        chk("rst_a_out", 128'(a_out), 128'(0));
        chk("rst_a_err", 128'(a_err), 128'(0));
        chk("rst_b_mv", 128'(b_mv), 128'(0));
        chk("rst_c_out", 128'(c_out), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_a_mv", 128'(a_mv), 128'(0));

        // single request from port 1
        a_rdy = 1'b1;
        a_addr[127:64] = 64'h1000;
        a_tag[3:2] = 2'd3;
        a_op[7:4] = 4'h2;
        a_rv = 2'b10;
        @(negedge clk);
        a_rv = 2'b00;
        chk("single_e1_mv", 128'(a_mv), 128'(0));
        @(negedge clk);
        chk("single_mv", 128'(a_mv), 128'(1));
        chk("single_ack", 128'(a_ack), 128'(2'b10));
        chk("single_addr", 128'(a_maddr), 128'(64'h1000));
        chk("single_tag", 128'(a_mtag), 128'(3));
        chk("single_op", 128'(a_mop), 128'(4'h2));
        chk("single_out", 128'(a_out), 128'(1));
        @(negedge clk);
        chk("single_drop_mv", 128'(a_mv), 128'(0));
        chk("single_drop_ack", 128'(a_ack), 128'(0));
        @(negedge clk);
        a_mrspv = 1'b1;
        a_mrspd = 128'hDEAD_BEEF_0000_0001;
        #1;
        chk("single_rspv", 128'(a_rspv), 128'(2'b10));
        chk("single_rld", a_rld, 128'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        a_mrspv = 1'b0;
        chk("single_out0", 128'(a_out), 128'(0));
        chk("single_err0", 128'(a_err), 128'(0));

        // backpressure on port 0, port 1 waits behind it
        a_rdy = 1'b0;
        a_addr[63:0] = 64'h2000;
        a_data[127:0] = 128'h5555_AAAA;
        a_rv = 2'b01;
        @(negedge clk);
        a_rv = 2'b00;
        @(negedge clk);
        chk("bp_mv", 128'(a_mv), 128'(1));
        chk("bp_ack", 128'(a_ack), 128'(2'b01));
        chk("bp_out", 128'(a_out), 128'(1));
        a_addr[127:64] = 64'h3000;
        a_rv = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_rv = 2'b00;
            chk("bp_hold_mv", 128'(a_mv), 128'(1));
            chk("bp_hold_addr", 128'(a_maddr), 128'(64'h2000));
            chk("bp_hold_data", a_mdata, 128'h5555_AAAA);
            chk("bp_hold_ack", 128'(a_ack), 128'(0));
        end
        a_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rel_mv", 128'(a_mv), 128'(0));
        chk("bp_rel_out", 128'(a_out), 128'(1));
        chk("bp_rel_ack", 128'(a_ack), 128'(0));
        a_mrspv = 1'b1;
        a_mrspd = 128'h2222;
        #1;
        chk("bp_rsp0", 128'(a_rspv), 128'(2'b01));
        @(negedge clk);
        a_mrspv = 1'b0;
        chk("bp_swap_mv", 128'(a_mv), 128'(1));
        chk("bp_swap_addr", 128'(a_maddr), 128'(64'h3000));
        chk("bp_swap_ack", 128'(a_ack), 128'(2'b10));
        chk("bp_swap_out", 128'(a_out), 128'(1));
        @(negedge clk);
        a_mrspv = 1'b1;
        a_mrspd = 128'h3333;
        #1;
        chk("bp_rsp1", 128'(a_rspv), 128'(2'b10));
        chk("bp_rld1", a_rld, 128'h3333);
        @(negedge clk);
        a_mrspv = 1'b0;
        chk("bp_out0", 128'(a_out), 128'(0));

        // spurious response
        a_mrspv = 1'b1;
        #1;
        chk("spur_rspv", 128'(a_rspv), 128'(0));
        @(negedge clk);
        a_mrspv = 1'b0;
        chk("spur_err", 128'(a_err), 128'(1));
        chk("spur_out", 128'(a_out), 128'(0));
        @(negedge clk);
        chk("spur_err_held", 128'(a_err), 128'(1));

        // round-robin, 4 ports
        b_addr[63:0]    = 64'h100;
        b_addr[127:64]  = 64'h200;
        b_addr[191:128] = 64'h300;
        b_addr[255:192] = 64'h400;
        b_rv = 4'b1111;
        @(negedge clk);
        b_rv = 4'b0000;
        @(negedge clk);
        chk("rr_g0_ack", 128'(b_ack), 128'(4'b0001));
        chk("rr_g0_addr", 128'(b_maddr), 128'(64'h100));
        b_addr[63:0] = 64'h500;
        b_rv = 4'b0001;
        @(negedge clk);
        b_rv = 4'b0000;
        chk("rr_g1_ack", 128'(b_ack), 128'(4'b0010));
        chk("rr_g1_addr", 128'(b_maddr), 128'(64'h200));
        @(negedge clk);
        chk("rr_g2_ack", 128'(b_ack), 128'(4'b0100));
        chk("rr_g2_addr", 128'(b_maddr), 128'(64'h300));
        @(negedge clk);
        chk("rr_g3_ack", 128'(b_ack), 128'(4'b1000));
        chk("rr_g3_addr", 128'(b_maddr), 128'(64'h400));
        @(negedge clk);
        chk("rr_g4_ack", 128'(b_ack), 128'(4'b0001));
        chk("rr_g4_addr", 128'(b_maddr), 128'(64'h500));
        chk("rr_out5", 128'(b_out), 128'(5));
        @(negedge clk);
        chk("rr_idle_mv", 128'(b_mv), 128'(0));

        // fixed priority with two outstanding
        c_addr[63:0]    = 64'hC00;
        c_addr[127:64]  = 64'hC01;
        c_addr[191:128] = 64'hC02;
        c_addr[255:192] = 64'hC03;
        c_rv = 4'b0111;
        @(negedge clk);
        c_rv = 4'b0000;
        @(negedge clk);
        chk("mo_i0_ack", 128'(c_ack), 128'(4'b0001));
        chk("mo_i0_addr", 128'(c_maddr), 128'(64'hC00));
        chk("mo_i0_out", 128'(c_out), 128'(1));
        @(negedge clk);
        chk("mo_i1_ack", 128'(c_ack), 128'(4'b0010));
        chk("mo_i1_addr", 128'(c_maddr), 128'(64'hC01));
        chk("mo_i1_out", 128'(c_out), 128'(2));
        @(negedge clk);
        chk("mo_full_ack", 128'(c_ack), 128'(0));
        chk("mo_full_mv", 128'(c_mv), 128'(0));
        chk("mo_full_out", 128'(c_out), 128'(2));
        c_addr[63:0] = 64'hD00;
        c_rv = 4'b1001;
        @(negedge clk);
        c_rv = 4'b0000;
        chk("mo_stall_mv", 128'(c_mv), 128'(0));
        chk("mo_stall_out", 128'(c_out), 128'(2));
        c_mrspv = 1'b1;
        c_mrspd = 128'hC0DE;
        #1;
        chk("mo_r0_rspv", 128'(c_rspv), 128'(4'b0001));
        chk("mo_r0_rld", c_rld, 128'hC0DE);
        @(negedge clk);
        chk("pr_g0_ack", 128'(c_ack), 128'(4'b0001));
        chk("pr_g0_addr", 128'(c_maddr), 128'(64'hD00));
        chk("mo_swap_out", 128'(c_out), 128'(2));
        #1;
        chk("mo_r1_rspv", 128'(c_rspv), 128'(4'b0010));
        @(negedge clk);
        chk("pr_g2_ack", 128'(c_ack), 128'(4'b0100));
        chk("pr_g2_addr", 128'(c_maddr), 128'(64'hC02));
        chk("mo_swap2_out", 128'(c_out), 128'(2));
        #1;
        chk("mo_r2_rspv", 128'(c_rspv), 128'(4'b0001));
        @(negedge clk);
        chk("pr_g3_ack", 128'(c_ack), 128'(4'b1000));
        #1;
        chk("mo_r3_rspv", 128'(c_rspv), 128'(4'b0100));
        @(negedge clk);
        chk("mo_drain_out1", 128'(c_out), 128'(1));
        chk("mo_drain_ack", 128'(c_ack), 128'(0));
        #1;
        chk("mo_r4_rspv", 128'(c_rspv), 128'(4'b1000));
        @(negedge clk);
        c_mrspv = 1'b0;
        chk("mo_drain_out0", 128'(c_out), 128'(0));
        chk("mo_err", 128'(c_err), 128'(0));

        // reset in flight
        a_rdy = 1'b0;
        a_addr[63:0] = 64'h4000;
        a_rv = 2'b01;
        @(negedge clk);
        a_rv = 2'b00;
        @(negedge clk);
        chk("mid_pre_mv", 128'(a_mv), 128'(1));
        chk("mid_pre_ack", 128'(a_ack), 128'(2'b01));
        chk("mid_pre_out", 128'(a_out), 128'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_mv", 128'(a_mv), 128'(0));
        chk("mid_rst_ack", 128'(a_ack), 128'(0));
        chk("mid_rst_out", 128'(a_out), 128'(0));
        chk("mid_rst_err", 128'(a_err), 128'(0));
        chk("mid_rst_addr", 128'(a_maddr), 128'(0));
        chk("mid_rst_b_out", 128'(b_out), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        a_rdy = 1'b1;
        a_addr[63:0]   = 64'h6000;
        a_addr[127:64] = 64'h7000;
        a_rv = 2'b11;
        @(negedge clk);
        a_rv = 2'b00;
        @(negedge clk);
        chk("rel_mv", 128'(a_mv), 128'(1));
        chk("rel_ack", 128'(a_ack), 128'(2'b01));
        chk("rel_addr", 128'(a_maddr), 128'(64'h6000));
        chk("rel_out", 128'(a_out), 128'(1));
        a_mrspv = 1'b1;
        #1;
        chk("rel_rspv0", 128'(a_rspv), 128'(2'b01));
        @(negedge clk);
        chk("rel_g1_ack", 128'(a_ack), 128'(2'b10));
        chk("rel_g1_addr", 128'(a_maddr), 128'(64'h7000));
        #1;
        chk("rel_rspv1", 128'(a_rspv), 128'(2'b10));
        @(negedge clk);
        chk("rel_out0", 128'(a_out), 128'(0));
        chk("rel_err0", 128'(a_err), 128'(0));
        @(negedge clk);
        a_mrspv = 1'b0;
        chk("rel_spur_err", 128'(a_err), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
